// File: rtl/nand_cpu_pkg.sv
// Shared nand_cpu fetch-path definitions: i-cache FSM states, statistic width, saturating increment.
package nand_cpu_pkg;

   typedef enum logic [1:0] {
      IC_READY   = 2'd0,
      IC_REQUEST = 2'd1,
      IC_FILL    = 2'd2
   } ICacheState;

   localparam int I_CACHE_STAT_BITS = 16;

   function automatic logic [I_CACHE_STAT_BITS-1:0] sat_inc(input logic [I_CACHE_STAT_BITS-1:0] v);
      return (v == {I_CACHE_STAT_BITS{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/i_cache_victim_sel.sv
// Replacement victim for one set: lowest-numbered invalid way, otherwise the set's round-robin pointer.
module i_cache_victim_sel #(
   parameter int WAYS     = 2,
   parameter int WAY_BITS = 1
) (
   input  logic [WAYS-1:0]     valid_vec,
   input  logic [WAY_BITS-1:0] rr_ptr,
   output logic [WAY_BITS-1:0] victim
);

   logic found_s;

   // Priority scan from way 0 so the lowest invalid way wins.
   always_comb begin
      victim  = rr_ptr;
      found_s = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found_s && !valid_vec[w]) begin
            victim  = WAY_BITS'(w);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/i_cache_assoc.sv
// Set-associative instruction cache with block refill over a req/ack + beat-valid memory port.
// Optional statistics counters are built when I_CACHE_STATS_EN is defined.
module i_cache_assoc
   import nand_cpu_pkg::*;
#(
   parameter int WAYS           = 2,
   parameter int INDEX_BITS     = 4,
   parameter int ADDR_BITS      = 16,
   parameter int INSTR_BITS     = 8,
   parameter int BLOCK_BITS     = 64,
   parameter int MEM_TRANS_BITS = 16,
   localparam int OFFSET_BITS   = $clog2(BLOCK_BITS / INSTR_BITS),
   localparam int TAG_BITS      = ADDR_BITS - INDEX_BITS - OFFSET_BITS
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             pc_valid,
   input  logic [ADDR_BITS-1:0]             pc,
   input  logic                             flush,
   output logic                             hit,
   output logic                             miss,
   output logic [INSTR_BITS-1:0]            instr,
`ifdef I_CACHE_STATS_EN
   output logic [I_CACHE_STAT_BITS-1:0]     hit_count,
   output logic [I_CACHE_STAT_BITS-1:0]     miss_count,
`endif
   output logic                             mem_req,
   output logic [ADDR_BITS-OFFSET_BITS-1:0] mem_addr,
   input  logic                             mem_ack,
   input  logic                             mem_data_valid,
   input  logic [MEM_TRANS_BITS-1:0]        mem_data
);

   localparam int SETS     = 2 ** INDEX_BITS;
   localparam int BEATS    = BLOCK_BITS / MEM_TRANS_BITS;
   localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

   ICacheState state_r, state_nx_s;

   logic [WAYS-1:0]       valid_r [SETS];
   logic [WAY_BITS-1:0]   rr_r    [SETS];
   logic [TAG_BITS-1:0]   tag_r   [SETS][WAYS];
   logic [BLOCK_BITS-1:0] data_r  [SETS][WAYS];

   logic [TAG_BITS-1:0]    tag_lat_r;
   logic [INDEX_BITS-1:0]  idx_lat_r;
   logic [WAY_BITS-1:0]    victim_r;
   logic [CNT_BITS-1:0]    cnt_r;
   logic                   flush_pend_r;

   logic [OFFSET_BITS-1:0] pc_offset_s;
   logic [INDEX_BITS-1:0]  pc_index_s;
   logic [TAG_BITS-1:0]    pc_tag_s;
   logic                   hit_any_s;
   logic [WAY_BITS-1:0]    hit_way_s;
   logic [WAY_BITS-1:0]    victim_s;
   logic [WAY_BITS-1:0]    rr_next_s;
   logic                   start_fill_s;
   logic                   last_beat_s;

   assign pc_offset_s = pc[OFFSET_BITS-1:0];
   assign pc_index_s  = pc[OFFSET_BITS +: INDEX_BITS];
   assign pc_tag_s    = pc[ADDR_BITS-1 -: TAG_BITS];

   // Tag compare across all ways of the addressed set.
   always_comb begin
      hit_any_s = 1'b0;
      hit_way_s = {WAY_BITS{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
         if (valid_r[pc_index_s][w] && (tag_r[pc_index_s][w] == pc_tag_s)) begin
            hit_any_s = 1'b1;
            hit_way_s = WAY_BITS'(w);
         end else begin
            hit_any_s = hit_any_s;
         end
      end
   end

   // A flush in READY suppresses both the hit and the start of a refill.
   assign hit          = (state_r == IC_READY) && pc_valid && hit_any_s && !flush;
   assign miss         = pc_valid && !hit;
   assign instr        = data_r[pc_index_s][hit_way_s][pc_offset_s*INSTR_BITS +: INSTR_BITS];
   assign start_fill_s = (state_r == IC_READY) && pc_valid && !hit_any_s && !flush;
   assign last_beat_s  = (cnt_r == CNT_BITS'(BEATS - 1));
   assign rr_next_s    = (rr_r[idx_lat_r] == WAY_BITS'(WAYS - 1)) ? {WAY_BITS{1'b0}}
                                                                  : rr_r[idx_lat_r] + 1'b1;
   assign mem_req      = (state_r == IC_REQUEST);
   assign mem_addr     = {tag_lat_r, idx_lat_r};

   i_cache_victim_sel #(
      .WAYS     (WAYS),
      .WAY_BITS (WAY_BITS)
   ) u_victim_sel (
      .valid_vec (valid_r[pc_index_s]),
      .rr_ptr    (rr_r[pc_index_s]),
      .victim    (victim_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r <= IC_READY;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IC_READY: begin
            if (start_fill_s) begin
               state_nx_s = IC_REQUEST;
            end else begin
               state_nx_s = IC_READY;
            end
         end
         IC_REQUEST: begin
            if (mem_ack) begin
               state_nx_s = IC_FILL;
            end else begin
               state_nx_s = IC_REQUEST;
            end
         end
         IC_FILL: begin
            if (mem_data_valid && last_beat_s) begin
               state_nx_s = IC_READY;
            end else begin
               state_nx_s = IC_FILL;
            end
         end
         default: state_nx_s = IC_READY;
      endcase
   end

   // Valid bits, round-robin pointers, beat counter, latched refill target and deferred flush.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_r[s] <= {WAYS{1'b0}};
            rr_r[s]    <= {WAY_BITS{1'b0}};
         end
         tag_lat_r    <= {TAG_BITS{1'b0}};
         idx_lat_r    <= {INDEX_BITS{1'b0}};
         victim_r     <= {WAY_BITS{1'b0}};
         cnt_r        <= {CNT_BITS{1'b0}};
         flush_pend_r <= 1'b0;
      end else begin
         case (state_r)
            IC_READY: begin
               if (flush) begin
                  for (int s = 0; s < SETS; s++) valid_r[s] <= {WAYS{1'b0}};
               end else if (start_fill_s) begin
                  tag_lat_r <= pc_tag_s;
                  idx_lat_r <= pc_index_s;
                  victim_r  <= victim_s;
               end
            end
            IC_REQUEST: begin
               if (flush) flush_pend_r <= 1'b1;
               if (mem_ack) begin
                  cnt_r                        <= {CNT_BITS{1'b0}};
                  valid_r[idx_lat_r][victim_r] <= 1'b0;
               end
            end
            IC_FILL: begin
               if (flush) flush_pend_r <= 1'b1;
               if (mem_data_valid) begin
                  cnt_r <= cnt_r + 1'b1;
                  if (last_beat_s) begin
                     rr_r[idx_lat_r] <= rr_next_s;
                     flush_pend_r    <= 1'b0;
                     if (flush_pend_r || flush) begin
                        for (int s = 0; s < SETS; s++) valid_r[s] <= {WAYS{1'b0}};
                     end else begin
                        valid_r[idx_lat_r][victim_r] <= 1'b1;
                     end
                  end
               end
            end
            default: flush_pend_r <= 1'b0;
         endcase
      end
   end

   // Line storage is written beat by beat; tag lands with the last beat. Not reset.
   always_ff @(posedge clk) begin
      if ((state_r == IC_FILL) && mem_data_valid) begin
         data_r[idx_lat_r][victim_r][cnt_r*MEM_TRANS_BITS +: MEM_TRANS_BITS] <= mem_data;
         if (last_beat_s) tag_r[idx_lat_r][victim_r] <= tag_lat_r;
      end
   end

`ifdef I_CACHE_STATS_EN
   logic [I_CACHE_STAT_BITS-1:0] hit_cnt_r;
   logic [I_CACHE_STAT_BITS-1:0] miss_cnt_r;

   // Saturating hit/miss statistics; flush leaves them alone.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         hit_cnt_r  <= {I_CACHE_STAT_BITS{1'b0}};
         miss_cnt_r <= {I_CACHE_STAT_BITS{1'b0}};
      end else begin
         if (hit) hit_cnt_r <= sat_inc(hit_cnt_r);
         if (start_fill_s) miss_cnt_r <= sat_inc(miss_cnt_r);
      end
   end

   assign hit_count  = hit_cnt_r;
   assign miss_count = miss_cnt_r;
`else
   // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_i_cache_assoc.sv
// Directed bench for i_cache_assoc at default parameters (4 beats, 3b offset, 4b index, 9b tag).
module tb_i_cache_assoc;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        pc_valid;
   logic [15:0] pc;
   logic        flush;
   logic        hit;
   logic        miss;
   logic [7:0]  instr;
   logic        mem_req;
   logic [12:0] mem_addr;
   logic        mem_ack;
   logic        mem_data_valid;
   logic [15:0] mem_data;
`ifdef I_CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   i_cache_assoc dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .pc_valid       (pc_valid),
      .pc             (pc),
      .flush          (flush),
      .hit            (hit),
      .miss           (miss),
      .instr          (instr),
`ifdef I_CACHE_STATS_EN
      .hit_count      (hit_count),
      .miss_count     (miss_count),
`endif
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_data_valid (mem_data_valid),
      .mem_data       (mem_data)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input logic [15:0] a);
      pc_valid = 1'b1;
      pc       = a;
      #1;
   endtask

   // Miss expected in READY; drop pc_valid before the edge so no refill starts.
   task automatic lookup_miss(input string tag, input logic [15:0] a);
      probe(a);
      check_val({tag, "_hit"}, hit, 1'b0);
      check_val({tag, "_miss"}, miss, 1'b1);
      pc_valid = 1'b0;
      step();
   endtask

   task automatic lookup_hit(input string tag, input logic [15:0] a, input logic [7:0] exp);
      probe(a);
      check_val({tag, "_hit"}, hit, 1'b1);
      check_val({tag, "_instr"}, instr, exp);
   endtask

   // From REQUEST: ack, then stream four beats following valid pattern vpat (bit i = cycle i).
   task automatic fill_beats(input string tag, input logic [63:0] blk, input logic [15:0] vpat);
      int beat;
      int i;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      beat = 0;
      i    = 0;
      while (beat < 4 && i < 32) begin
         mem_data_valid = vpat[i % 16];
         mem_data       = vpat[i % 16] ? blk[beat*16 +: 16] : 16'hDEAD;
         if (vpat[i % 16]) beat++;
         i++;
         step();
      end
      mem_data_valid = 1'b0;
      check_val({tag, "_beats"}, beat, 4);
   endtask

   // Caller has a missing pc presented in READY.
   task automatic refill(input string tag, input logic [12:0] addr_exp, input logic [63:0] blk,
                         input logic [15:0] vpat);
      check_val({tag, "_miss"}, miss, 1'b1);
      step();
      check_val({tag, "_req"}, mem_req, 1'b1);
      check_val({tag, "_addr"}, mem_addr, addr_exp);
      fill_beats(tag, blk, vpat);
   endtask

   initial begin
      n_rst = 1'b0; pc_valid = 1'b0; pc = 16'h0000; flush = 1'b0;
      mem_ack = 1'b0; mem_data_valid = 1'b0; mem_data = 16'h0000;
      step();
      step();
      check_val("rst_hit", hit, 1'b0);
      check_val("rst_req", mem_req, 1'b0);
      check_val("rst_miss", miss, 1'b0);
      n_rst = 1'b1;
      step();

      // Cold miss and word selection within the block
      probe(16'h0010);
      refill("cold", 13'h002, 64'h7766_5544_3322_1100, 16'hFFFF);
      lookup_hit("cold0", 16'h0010, 8'h00);
      lookup_hit("cold5", 16'h0015, 8'h55);
      lookup_hit("cold7", 16'h0017, 8'h77);

      // Second way in set 2, then a third tag (with beat gaps) evicts way 0
      probe(16'h0410);
      refill("way1", 13'h082, 64'hF7F6_F5F4_F3F2_F1F0, 16'hFFFF);
      lookup_hit("way1_a", 16'h0410, 8'hF0);
      lookup_hit("way0_a", 16'h0010, 8'h00);
      probe(16'h0813);
      refill("gap", 13'h102, 64'hA7A6_A5A4_A3A2_A1A0, 16'h0059);
      lookup_hit("gap_hit", 16'h0813, 8'hA3);
      lookup_miss("evict0", 16'h0010);
      lookup_hit("keep1", 16'h0416, 8'hF6);

      // Flush during FILL after beat 1
      probe(16'h0020);
      check_val("fl_miss", miss, 1'b1);
      step();
      check_val("fl_addr", mem_addr, 13'h004);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_data_valid = 1'b1; mem_data = 16'h1234; step();
      end
      mem_data_valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_data_valid = 1'b1; mem_data = 16'h5678; step();
      end
      mem_data_valid = 1'b0;
      pc_valid = 1'b0;
      #1;
      check_val("fl_idle0", mem_req, 1'b0);
      step();
      check_val("fl_idle1", mem_req, 1'b0);
      lookup_miss("fl_new", 16'h0020);
      lookup_miss("fl_old1", 16'h0813);
      lookup_miss("fl_old2", 16'h0410);

      // Flush in READY together with a lookup: flush wins, no refill
      probe(16'h0030);
      refill("flr", 13'h006, 64'h3736_3534_3332_3130, 16'hFFFF);
      lookup_hit("flr_pre", 16'h0030, 8'h30);
      flush = 1'b1;
      #1;
      check_val("flr_hit", hit, 1'b0);
      check_val("flr_miss", miss, 1'b1);
      step();
      flush = 1'b0;
      #1;
      check_val("flr_noreq", mem_req, 1'b0);
      check_val("flr_gone", miss, 1'b1);
      pc_valid = 1'b0;
      step();

      // Stall in REQUEST: request held steady while pc wanders, even onto a cached line
      probe(16'h0050);
      refill("pre", 13'h00A, 64'h5756_5554_5352_5150, 16'hFFFF);
      lookup_hit("pre_hit", 16'h0050, 8'h50);
      probe(16'h0040);
      check_val("st_miss", miss, 1'b1);
      step();
      for (int c = 0; c < 10; c++) begin
         pc_valid = ((c % 2) == 0);
         pc       = ((c % 3) == 0) ? 16'h0050 : 16'h1200 + 16'(c);
         #1;
         check_val("st_req", mem_req, 1'b1);
         check_val("st_addr", mem_addr, 13'h008);
         check_val("st_hit", hit, 1'b0);
         check_val("st_miss", miss, pc_valid);
         step();
      end
      fill_beats("st", 64'h4746_4544_4342_4140, 16'hFFFF);
      lookup_hit("st_hit4", 16'h0044, 8'h44);
      lookup_hit("st_other", 16'h0050, 8'h50);

      // Reset during FILL
      probe(16'h0060);
      step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      mem_data_valid = 1'b1; mem_data = 16'h6160;
      step();
      mem_data_valid = 1'b0;
      pc_valid = 1'b0;
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      #1;
      check_val("rf_req0", mem_req, 1'b0);
`ifdef I_CACHE_STATS_EN
      check_val("rf_hcnt", hit_count, 16'h0000);
      check_val("rf_mcnt", miss_count, 16'h0000);
`endif
      step();
      check_val("rf_req1", mem_req, 1'b0);
      lookup_miss("rf_a", 16'h0040);
      lookup_miss("rf_b", 16'h0050);
      lookup_miss("rf_c", 16'h0060);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
